// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with a double-buffered display
// image, per-digit blanking interval, leading-zero suppression and blinking.
module seg7_scan_driver #(
  parameter int DIGITS       = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_in,
  input  logic                  load,
  input  logic                  lz_en,
  output logic [DIGITS-1:0]     anode,
  output logic [7:0]            cathode,
  output logic                  frame_start
);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]  BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(DIGITS - 1);
  localparam logic [FRM_W-1:0]  FRM_MAX   = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [DIGITS-1:0] AN_ONE    = DIGITS'(1);

  logic [4*DIGITS-1:0] shd_data_q, shd_data_d, act_data_q, act_data_d;
  logic [DIGITS-1:0]   shd_dp_q, shd_dp_d, act_dp_q, act_dp_d;
  logic [DIGITS-1:0]   shd_blink_q, shd_blink_d, act_blink_q, act_blink_d;
  logic                pending_q, pending_d, run_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [FRM_W-1:0]    frm_q, frm_d;
  logic                phase_q, phase_d;
  logic [DIGITS-1:0]   anode_q, anode_d;
  logic [7:0]          cathode_q, cathode_d;
  logic                frame_start_q, frame_start_d;
  logic                slot_end, wrap;
  logic [3:0]          nib;
  logic                dp_bit, blk_bit, upper_nz, suppress;

  // Segment pattern {G,F,E,D,C,B,A}, active-low.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
    endcase
  endfunction

  // The counters name the slot position about to be emitted; the first edge after
  // reset emits position (0,0) without advancing, so that frame is not a wrap.
  always_comb begin
    slot_end = run_q && (cnt_q == CNT_MAX);
    wrap     = slot_end && (idx_q == IDX_MAX);
    cnt_d    = (!run_q || cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (!run_q || wrap)  idx_d = '0;
    else if (slot_end)   idx_d = idx_q + 1'b1;

    shd_data_d  = load ? data_in  : shd_data_q;
    shd_dp_d    = load ? dp_in    : shd_dp_q;
    shd_blink_d = load ? blink_in : shd_blink_q;
    act_data_d  = (wrap && pending_q) ? shd_data_q  : act_data_q;
    act_dp_d    = (wrap && pending_q) ? shd_dp_q    : act_dp_q;
    act_blink_d = (wrap && pending_q) ? shd_blink_q : act_blink_q;
    pending_d   = load | (pending_q & ~wrap);

    frm_d   = frm_q;
    phase_d = phase_q;
    if (wrap) begin
      if (frm_q == FRM_MAX) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end
  end

  // Output decode uses next-state values so the new image and frame_start coincide.
  always_comb begin
    nib      = 4'h0;
    dp_bit   = 1'b0;
    blk_bit  = 1'b0;
    upper_nz = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == idx_d) begin
        nib     = act_data_d[4*i +: 4];
        dp_bit  = act_dp_d[i];
        blk_bit = act_blink_d[i];
      end
      if (IDX_W'(i) >= idx_d && act_data_d[4*i +: 4] != 4'h0) upper_nz = 1'b1;
    end
    suppress = lz_en && (idx_d != '0) && !upper_nz;
    if (blk_bit && phase_d) cathode_d = 8'hFF;
    else                    cathode_d = {~dp_bit, suppress ? 7'h7F : glyph(nib)};
    anode_d       = (cnt_d < BLANK_END) ? '1 : ~(AN_ONE << idx_d);
    frame_start_d = (cnt_d == '0) && (idx_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_data_q    <= '0;
      shd_dp_q      <= '0;
      shd_blink_q   <= '0;
      act_data_q    <= '0;
      act_dp_q      <= '0;
      act_blink_q   <= '0;
      pending_q     <= 1'b0;
      run_q         <= 1'b0;
      cnt_q         <= '0;
      idx_q         <= '0;
      frm_q         <= '0;
      phase_q       <= 1'b0;
      anode_q       <= '1;
      cathode_q     <= 8'hFF;
      frame_start_q <= 1'b0;
    end else begin
      shd_data_q    <= shd_data_d;
      shd_dp_q      <= shd_dp_d;
      shd_blink_q   <= shd_blink_d;
      act_data_q    <= act_data_d;
      act_dp_q      <= act_dp_d;
      act_blink_q   <= act_blink_d;
      pending_q     <= pending_d;
      run_q         <= 1'b1;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      frm_q         <= frm_d;
      phase_q       <= phase_d;
      anode_q       <= anode_d;
      cathode_q     <= cathode_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign anode       = anode_q;
  assign cathode     = cathode_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with 4 digits, 8-cycle slots, 2 blank cycles.
module tb_seg7_scan_driver;
  localparam int D = 4, RD = 8, BL = 2, BF = 2;
  localparam int FRAME = D * RD;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  data_in = '0;
  logic [3:0]   dp_in = '0, blink_in = '0;
  logic         load = 1'b0, lz_en = 1'b0;
  logic [3:0]   anode;
  logic [7:0]   cathode;
  logic         frame_start;

  seg7_scan_driver #(.DIGITS(D), .REFRESH_DIV(RD), .BLANK_CYCLES(BL), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in), .blink_in(blink_in),
    .load(load), .lz_en(lz_en), .anode(anode), .cathode(cathode), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic        lz;
    logic [31:0] exp;   // {digit3, digit2, digit1, digit0} cathode
  } vec_t;

  vec_t vecs [8];
  int   tests = 0, fails = 0, cyc = -1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int f, input int d, input int c);
    int t;
    t = f * FRAME + d * RD + c;
    while (cyc < t) step();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    data_in = d; dp_in = dp; blink_in = bl; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    vec_t       v;
    logic [7:0] e;
    logic [3:0] a_exp;
    vecs[0] = '{16'hFEDC, 4'b0000, 1'b0, 32'h8E86A1C6};
    vecs[1] = '{16'hBA98, 4'b0000, 1'b0, 32'h83889080};
    vecs[2] = '{16'h7654, 4'b0000, 1'b0, 32'hF8829299};
    vecs[3] = '{16'h3210, 4'b0000, 1'b0, 32'hB0A4F9C0};
    vecs[4] = '{16'h0050, 4'b1000, 1'b1, 32'h7FFF92C0};
    vecs[5] = '{16'h0050, 4'b1000, 1'b0, 32'h40C092C0};
    vecs[6] = '{16'h0000, 4'b0101, 1'b1, 32'hFF7FFF40};
    vecs[7] = '{16'h1000, 4'b0000, 1'b1, 32'hF9C0C0C0};

    // Reset held
    repeat (3) @(posedge clk);
    #1;
    chk("rst_anode", {4'h0, anode}, 8'h0F);
    chk("rst_cathode", cathode, 8'hFF);
    chk("rst_fs", {7'h0, frame_start}, 8'h00);

    @(negedge clk);
    rst_n = 1'b1;
    cyc = -1;
    goto(0, 0, 0);
    chk("idle_fs0", {7'h0, frame_start}, 8'h01);
    chk("idle_an0", {4'h0, anode}, 8'h0F);
    chk("idle_cat0", cathode, 8'hC0);
    goto(0, 0, 1);
    chk("idle_fs1", {7'h0, frame_start}, 8'h00);
    chk("idle_an1", {4'h0, anode}, 8'h0F);
    goto(0, 0, 2);
    chk("idle_an2", {4'h0, anode}, 8'h0E);
    goto(0, 0, 7);
    chk("idle_an7", {4'h0, anode}, 8'h0E);
    goto(0, 1, 0);
    chk("idle_an_d1_blank", {4'h0, anode}, 8'h0F);
    chk("idle_fs_d1", {7'h0, frame_start}, 8'h00);
    goto(0, 1, 2);
    chk("idle_an_d1", {4'h0, anode}, 8'h0D);

    // Table: load mid-frame, verify every digit of the following frame
    for (int k = 0; k < 8; k++) begin
      v = vecs[k];
      goto(1 + 2 * k, 0, 5);
      lz_en = v.lz;
      do_load(v.data, v.dp, 4'b0000);
      goto(2 + 2 * k, 0, 0);
      chk($sformatf("vec%0d_fs", k), {7'h0, frame_start}, 8'h01);
      for (int d = 0; d < D; d++) begin
        goto(2 + 2 * k, d, 4);
        e = v.exp[8*d +: 8];
        a_exp = ~(4'b0001 << d);
        chk($sformatf("vec%0d_cat_d%0d", k, d), cathode, e);
        chk($sformatf("vec%0d_an_d%0d", k, d), {4'h0, anode}, {4'h0, a_exp});
      end
    end

    // Mid-frame load must not tear the current frame
    lz_en = 1'b0;
    goto(17, 1, 3);
    do_load(16'h1234, 4'b0000, 4'b0000);
    goto(17, 2, 4); chk("db_same_d2", cathode, 8'hC0);
    goto(17, 3, 4); chk("db_same_d3", cathode, 8'hF9);
    goto(18, 0, 4); chk("db_new_d0", cathode, 8'h99);
    goto(18, 1, 4); chk("db_new_d1", cathode, 8'hB0);

    // Back-to-back loads: last one wins
    goto(18, 2, 0);
    do_load(16'hAAAA, 4'b0000, 4'b0000);
    do_load(16'h5555, 4'b0000, 4'b0000);
    goto(18, 3, 4); chk("rep_old_d3", cathode, 8'hF9);
    goto(19, 0, 4); chk("rep_last_d0", cathode, 8'h92);

    // Load on the boundary edge is shown one frame later
    goto(19, 3, 7);
    do_load(16'h7777, 4'b0000, 4'b0000);
    chk("bnd_fs", {7'h0, frame_start}, 8'h01);
    goto(20, 0, 4); chk("bnd_prev_d0", cathode, 8'h92);
    goto(21, 0, 4); chk("bnd_new_d0", cathode, 8'hF8);

    // Blink: phase of frame f is (f / BF) % 2
    goto(21, 1, 0);
    do_load(16'h8888, 4'b0001, 4'b0001);
    for (int f = 22; f < 27; f++) begin
      goto(f, 0, 4);
      e = (((f / BF) % 2) == 1) ? 8'hFF : 8'h00;
      chk($sformatf("blink_f%0d_d0", f), cathode, e);
      goto(f, 1, 4);
      chk($sformatf("blink_f%0d_d1", f), cathode, 8'h80);
    end

    // Async reset mid-slot with a load pending
    goto(27, 1, 2);
    do_load(16'h4444, 4'b0000, 4'b0000);
    goto(27, 2, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_anode", {4'h0, anode}, 8'h0F);
    chk("arst_cathode", cathode, 8'hFF);
    chk("arst_fs", {7'h0, frame_start}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = -1;
    goto(0, 0, 0);
    chk("arst_rel_fs", {7'h0, frame_start}, 8'h01);
    chk("arst_rel_cat", cathode, 8'hC0);
    goto(0, 0, 2); chk("arst_rel_an", {4'h0, anode}, 8'h0E);
    goto(1, 0, 0); chk("arst_f1_fs", {7'h0, frame_start}, 8'h01);
    goto(1, 0, 4); chk("arst_f1_d0", cathode, 8'hC0);
    goto(1, 3, 4); chk("arst_f1_d3", cathode, 8'hC0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
